instruction_fetch_queue: RTL and testbench
==========================================

// Module: instruction_fetch_queue
// PURPOSE
//  Fetch stage directly downstream of the program counter. Takes the current PC and issues
//  in-order instruction-memory reads. Drives the PC's 2-bit PS select so the PC advances only
//  on accepted requests. Buffers returned 32-bit LEGv8 instructions, tagged with their PC, in a
//  DEPTH-entry ring toward decode (valid/ready). Flushes on redirect.
// PARAMETERS
//  DEPTH   4   ring entries = max requests in flight + buffered; power of 2, >= 2
//  ADDR_W  64  PC / address width
//  INST_W  32  instruction width
// PORTS
//  clock        in   1       single clock, all state on rising edge
//  reset        in   1       synchronous, active-low
//  pc_in        in   ADDR_W  current PC from the PC stage
//  ps_out       out  2       PS select to the PC: 00 hold, 01 PC+4, 10 load
//  redirect     in   1       branch/flush; the PC's load value comes from elsewhere
//  imem_req     out  1       read request
//  imem_addr    out  ADDR_W  read address (= pc_in)
//  imem_gnt     in   1       request accepted this cycle (when imem_req=1)
//  imem_rvalid  in   1       read data valid; responses return in request order
//  imem_rdata   in   INST_W  read data
//  inst_valid   out  1       head entry filled
//  inst         out  INST_W  head instruction
//  inst_pc      out  ADDR_W  PC of head instruction
//  inst_ready   in   1       decode accepts head
//  err          out  1       sticky protocol error (unexpected rvalid)
// BEHAVIOUR
//  - State: ring of {pc, data, filled}; pointers alloc/fill/rd; occ (log2(DEPTH)+1 bits);
//    discard_cnt (log2(DEPTH)+1 bits); err.
//  - reset low at an edge: pointers, occ, discard_cnt, err, filled[] and storage -> 0.
//    While reset is low: imem_req=0, ps_out=00, inst_valid=0; inst/inst_pc read 0 after reset.
//  - Issue: imem_req = reset & ~redirect & (occ < DEPTH), using registered occ only.
//    No combinational path from inst_ready to imem_req.
//  - On imem_req & imem_gnt: allocate slot at alloc, pc <- pc_in, filled <- 0, alloc++.
//  - ps_out (combinational): redirect ? 10 : (imem_req & imem_gnt) ? 01 : 00.
//    The PC therefore advances in the same cycle as the grant.
//  - Response with discard_cnt==0 and unfilled slots: data[fill] <- rdata, filled <- 1, fill++.
//    Response with discard_cnt>0: data dropped, discard_cnt--.
//    Response with neither: dropped, err <- 1 (held until reset).
//  - Dequeue: inst_valid = filled[rd]. On inst_valid & inst_ready: filled[rd] <- 0, rd++.
//  - occ: +1 on grant, -1 on dequeue; simultaneous grant and dequeue -> unchanged.
//  - Minimum latency: grant at cycle N, rvalid at N+1 -> inst_valid at N+2. No bypass.
//  - Pointers wrap modulo DEPTH (natural binary wrap).
//  - Redirect (highest priority):
//    - No request issued that cycle; all slots invalidated; alloc=fill=rd=0; occ=0.
//    - discard_cnt <- discard_cnt + unfilled - (imem_rvalid ? 1 : 0), where unfilled = alloc-fill
//      slot count. A response arriving in the redirect cycle belongs to the old stream and is
//      dropped; if discard_cnt and unfilled are both 0, it sets err.
//    - inst_valid=0 from the next cycle. Issue resumes the cycle after redirect, while any
//      discards are still pending.
//  - Instruction memory is reset together with this block; no responses arrive after reset.
// STRUCTURE
//  - Shared package legv8_fetch_pkg: PS_HOLD=2'b00, PS_INC=2'b01, PS_LOAD=2'b10, PS_BR=2'b11;
//    INST_W; entry struct {pc, data, filled}.
//  - Sub-module fetch_ring: storage plus alloc/fill/rd pointers and occ.
//    Top level: issue logic, PS generation, discard/err tracking.
// TESTING
//  1 Reset: reset=0 for 2 cycles, pc_in=0x100, gnt=1
//    -> imem_req=0, ps_out=00, inst_valid=0; first cycle after release imem_req=1, addr=0x100.
//  2 Stream: gnt=1, rvalid one cycle after each grant, rdata=0x8B000000+n, inst_ready=1
//    -> ps_out=01 every grant cycle; insts at PCs 0x100,0x104,0x108... in order, one per cycle.
//  3 Full: inst_ready=0, DEPTH=4 -> exactly 4 grants, then imem_req=0 and ps_out=00;
//    one inst_ready pulse -> exactly one new request on the following cycle.
//  4 Redirect with 2 requests unfilled -> ps_out=10 that cycle, imem_req=0; inst_valid=0 next;
//    next 2 rvalids dropped; first instruction delivered is for the new pc_in.
//  5 Redirect in the same cycle as an rvalid with 1 unfilled -> that response dropped,
//    discard_cnt=0, next response is accepted; err stays 0.
//  6 rvalid with nothing outstanding -> err=1, no inst_valid; err stays 1 until reset low.

Source files
------------

// File: rtl/legv8_fetch_pkg.sv
// Shared fetch-stage definitions: PC stage select codes, instruction width and the
// fetch ring entry layout.
package legv8_fetch_pkg;

   localparam logic [1:0] PS_HOLD = 2'b00;
   localparam logic [1:0] PS_INC  = 2'b01;
   localparam logic [1:0] PS_LOAD = 2'b10;
   localparam logic [1:0] PS_BR   = 2'b11;

   localparam int INST_W = 32;
   localparam int PC_W   = 64;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] data;
      logic              filled;
   } entry_t;

endpackage

// File: rtl/fetch_ring.sv
// Fetch ring: slots allocated in request order, filled in response order, drained at rd.
// No bypass: a fill is visible at the head the cycle after it is written; flush clears everything.
module fetch_ring #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 64,
   parameter int DATA_W = 32,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              alloc_en,
   input  logic [ADDR_W-1:0] alloc_pc,
   input  logic              fill_en,
   input  logic [DATA_W-1:0] fill_data,
   input  logic              deq_en,
   output logic [PW:0]       occ,
   output logic [PW:0]       unfilled,
   output logic              head_filled,
   output logic [DATA_W-1:0] head_data,
   output logic [ADDR_W-1:0] head_pc
);

   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]  filled_q;
   // alloc/fill carry an extra wrap bit so alloc-fill distinguishes empty from all-unfilled
   logic [PW:0]       alloc_q, fill_q;
   logic [PW-1:0]     rd_q;
   logic [PW:0]       occ_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         alloc_q  <= '0;
         fill_q   <= '0;
         rd_q     <= '0;
         occ_q    <= '0;
         filled_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else if (flush) begin
         alloc_q  <= '0;
         fill_q   <= '0;
         rd_q     <= '0;
         occ_q    <= '0;
         filled_q <= '0;
      end else begin
         // alloc, fill and deq always address distinct slots, so the writes never collide
         if (alloc_en) begin
            pc_q[alloc_q[PW-1:0]]     <= alloc_pc;
            filled_q[alloc_q[PW-1:0]] <= 1'b0;
            alloc_q                   <= alloc_q + 1'b1;
         end
         if (fill_en) begin
            data_q[fill_q[PW-1:0]]   <= fill_data;
            filled_q[fill_q[PW-1:0]] <= 1'b1;
            fill_q                   <= fill_q + 1'b1;
         end
         if (deq_en) begin
            filled_q[rd_q] <= 1'b0;
            rd_q           <= rd_q + 1'b1;
         end
         if (alloc_en && !deq_en)
            occ_q <= occ_q + 1'b1;
         else if (!alloc_en && deq_en)
            occ_q <= occ_q - 1'b1;
      end
   end

   assign occ         = occ_q;
   assign unfilled    = alloc_q - fill_q;
   assign head_filled = filled_q[rd_q];
   assign head_data   = data_q[rd_q];
   assign head_pc     = pc_q[rd_q];

endmodule

// File: rtl/instruction_fetch_queue.sv
// In-order instruction fetch: issues imem reads at pc_in, steers the PC, buffers tagged
// instructions toward decode; grant-to-inst_valid is 2 cycles, issue stalls when the ring is full.
module instruction_fetch_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 64,
   parameter int INST_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc_in,
   output logic [1:0]        ps_out,
   input  logic              redirect,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              inst_ready,
   output logic              err
);
   import legv8_fetch_pkg::*;

   localparam int          PW     = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   logic [PW:0] occ, unfilled, discard_q, discard_sum;
   logic        grant, fill_en, deq_en, head_filled, err_q;

   // issue depends only on registered occupancy, never on inst_ready
   assign imem_req  = reset & ~redirect & (occ < DEPTH_C);
   assign imem_addr = pc_in;
   assign grant     = imem_req & imem_gnt;

   always_comb begin
      ps_out = PS_HOLD;
      if (!reset)        ps_out = PS_HOLD;
      else if (redirect) ps_out = PS_LOAD;
      else if (grant)    ps_out = PS_INC;
   end

   assign fill_en    = imem_rvalid & ~redirect & (discard_q == '0) & (unfilled != '0);
   assign inst_valid = reset & head_filled;
   assign deq_en     = inst_valid & inst_ready;

   assign discard_sum = discard_q + unfilled;

   always_ff @(posedge clock) begin
      if (!reset) begin
         discard_q <= '0;
         err_q     <= 1'b0;
      end else if (redirect) begin
         // outstanding old-stream responses become discards; one arriving now is consumed here
         if (imem_rvalid) begin
            if (discard_sum == '0) err_q <= 1'b1;
            else                   discard_q <= discard_sum - 1'b1;
         end else begin
            discard_q <= discard_sum;
         end
      end else if (imem_rvalid) begin
         if (discard_q != '0)       discard_q <= discard_q - 1'b1;
         else if (unfilled == '0)   err_q <= 1'b1;
      end
   end

   assign err = err_q;

   fetch_ring #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W),
      .DATA_W(INST_W)
   ) u_ring (
      .clock      (clock),
      .reset      (reset),
      .flush      (redirect),
      .alloc_en   (grant),
      .alloc_pc   (pc_in),
      .fill_en    (fill_en),
      .fill_data  (imem_rdata),
      .deq_en     (deq_en),
      .occ        (occ),
      .unfilled   (unfilled),
      .head_filled(head_filled),
      .head_data  (inst),
      .head_pc    (inst_pc)
   );

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: reset, streaming, full stall, redirect with
// discards, redirect colliding with a response, and the sticky protocol error.
module tb_instruction_fetch_queue;

   logic        clock = 1'b0;
   logic        reset;
   logic [63:0] pc_in;
   logic [1:0]  ps_out;
   logic        redirect;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        inst_ready;
   logic        err;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   instruction_fetch_queue #(.DEPTH(4), .ADDR_W(64), .INST_W(32)) dut (
      .clock      (clock),
      .reset      (reset),
      .pc_in      (pc_in),
      .ps_out     (ps_out),
      .redirect   (redirect),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_gnt   (imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .inst_valid (inst_valid),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .inst_ready (inst_ready),
      .err        (err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // drive inputs at the falling edge, then let combinational outputs settle
   task automatic drive(input logic rst, input logic [63:0] pc, input logic rdr,
                        input logic gnt, input logic rv, input logic [31:0] rd,
                        input logic rdy);
      @(negedge clock);
      reset = rst; pc_in = pc; redirect = rdr; imem_gnt = gnt;
      imem_rvalid = rv; imem_rdata = rd; inst_ready = rdy;
      #1;
   endtask

   initial begin
      reset = 1'b0; pc_in = 64'h100; redirect = 1'b0; imem_gnt = 1'b1;
      imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;

      // 1: reset held low for two cycles
      drive(1'b0, 64'h100, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("rst_req", {63'h0, imem_req}, 64'h0);
      chk("rst_ps", {62'h0, ps_out}, 64'h0);
      chk("rst_valid", {63'h0, inst_valid}, 64'h0);
      drive(1'b0, 64'h100, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("rst_req2", {63'h0, imem_req}, 64'h0);
      chk("rst_inst", {32'h0, inst}, 64'h0);
      chk("rst_inst_pc", inst_pc, 64'h0);
      chk("rst_err", {63'h0, err}, 64'h0);

      // 2: streaming, one grant and one response per cycle, decode always ready
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 64'h100 + 64'(4*k), 1'b0, 1'b1, k >= 1, 32'h8B000000 + 32'(k-1), 1'b1);
         chk("str_req", {63'h0, imem_req}, 64'h1);
         chk("str_addr", imem_addr, 64'h100 + 64'(4*k));
         chk("str_ps", {62'h0, ps_out}, 64'h1);
         chk("str_valid", {63'h0, inst_valid}, (k >= 2) ? 64'h1 : 64'h0);
         if (k >= 2) begin
            chk("str_inst", {32'h0, inst}, {32'h0, 32'h8B000000 + 32'(k-2)});
            chk("str_pc", inst_pc, 64'h100 + 64'(4*(k-2)));
         end
      end
      drive(1'b1, 64'h118, 1'b0, 1'b0, 1'b1, 32'h8B000005, 1'b1);
      chk("drain_ps", {62'h0, ps_out}, 64'h0);
      chk("drain_inst", {32'h0, inst}, 64'h8B000004);
      chk("drain_pc", inst_pc, 64'h110);
      drive(1'b1, 64'h118, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("drain_inst2", {32'h0, inst}, 64'h8B000005);
      chk("drain_pc2", inst_pc, 64'h114);
      drive(1'b1, 64'h118, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("drain_empty", {63'h0, inst_valid}, 64'h0);

      // 3: decode stalled, ring fills after exactly four grants
      drive(1'b1, 64'h118, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("full_ps0", {62'h0, ps_out}, 64'h1);
      drive(1'b1, 64'h11C, 1'b0, 1'b1, 1'b1, 32'hA0, 1'b0);
      chk("full_ps1", {62'h0, ps_out}, 64'h1);
      drive(1'b1, 64'h120, 1'b0, 1'b1, 1'b1, 32'hA1, 1'b0);
      chk("full_ps2", {62'h0, ps_out}, 64'h1);
      drive(1'b1, 64'h124, 1'b0, 1'b1, 1'b1, 32'hA2, 1'b0);
      chk("full_ps3", {62'h0, ps_out}, 64'h1);
      drive(1'b1, 64'h128, 1'b0, 1'b1, 1'b1, 32'hA3, 1'b0);
      chk("full_req", {63'h0, imem_req}, 64'h0);
      chk("full_ps", {62'h0, ps_out}, 64'h0);
      chk("full_head", {32'h0, inst}, 64'hA0);
      chk("full_head_pc", inst_pc, 64'h118);
      drive(1'b1, 64'h128, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("full_req2", {63'h0, imem_req}, 64'h0);
      drive(1'b1, 64'h128, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("pulse_req", {63'h0, imem_req}, 64'h0);
      chk("pulse_valid", {63'h0, inst_valid}, 64'h1);
      drive(1'b1, 64'h128, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("after_pulse_req", {63'h0, imem_req}, 64'h1);
      chk("after_pulse_ps", {62'h0, ps_out}, 64'h1);
      chk("after_pulse_addr", imem_addr, 64'h128);
      drive(1'b1, 64'h12C, 1'b0, 1'b1, 1'b1, 32'hA4, 1'b0);
      chk("refull_req", {63'h0, imem_req}, 64'h0);
      chk("refull_head", {32'h0, inst}, 64'hA1);

      // 4: drain two, issue two, then redirect with both unfilled
      drive(1'b1, 64'h12C, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      drive(1'b1, 64'h12C, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("pre_rd_head", {32'h0, inst}, 64'hA2);
      drive(1'b1, 64'h12C, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("pre_rd_head2", {32'h0, inst}, 64'hA3);
      drive(1'b1, 64'h130, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("pre_rd_ps", {62'h0, ps_out}, 64'h1);
      drive(1'b1, 64'h134, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("rd_ps", {62'h0, ps_out}, 64'h2);
      chk("rd_req", {63'h0, imem_req}, 64'h0);
      drive(1'b1, 64'h200, 1'b0, 1'b1, 1'b1, 32'hDEAD0000, 1'b1);
      chk("rd_valid_next", {63'h0, inst_valid}, 64'h0);
      chk("rd_resume_req", {63'h0, imem_req}, 64'h1);
      chk("rd_resume_addr", imem_addr, 64'h200);
      drive(1'b1, 64'h204, 1'b0, 1'b0, 1'b1, 32'hDEAD0001, 1'b1);
      chk("rd_drop1", {63'h0, inst_valid}, 64'h0);
      chk("rd_hold_ps", {62'h0, ps_out}, 64'h0);
      drive(1'b1, 64'h204, 1'b0, 1'b0, 1'b1, 32'hC0, 1'b1);
      chk("rd_drop2", {63'h0, inst_valid}, 64'h0);
      drive(1'b1, 64'h204, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("rd_new_valid", {63'h0, inst_valid}, 64'h1);
      chk("rd_new_inst", {32'h0, inst}, 64'hC0);
      chk("rd_new_pc", inst_pc, 64'h200);
      chk("rd_err", {63'h0, err}, 64'h0);

      // 5: redirect coincides with the only outstanding response
      drive(1'b1, 64'h204, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      drive(1'b1, 64'h208, 1'b1, 1'b1, 1'b1, 32'hDEAD0002, 1'b0);
      chk("coll_ps", {62'h0, ps_out}, 64'h2);
      drive(1'b1, 64'h300, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("coll_valid", {63'h0, inst_valid}, 64'h0);
      drive(1'b1, 64'h304, 1'b0, 1'b0, 1'b1, 32'hD0, 1'b0);
      drive(1'b1, 64'h304, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("coll_accept", {63'h0, inst_valid}, 64'h1);
      chk("coll_inst", {32'h0, inst}, 64'hD0);
      chk("coll_pc", inst_pc, 64'h300);
      chk("coll_err", {63'h0, err}, 64'h0);

      // 6: unsolicited response sets sticky err
      drive(1'b1, 64'h304, 1'b0, 1'b0, 1'b1, 32'hBAD, 1'b0);
      drive(1'b1, 64'h304, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("err_set", {63'h0, err}, 64'h1);
      chk("err_no_valid", {63'h0, inst_valid}, 64'h0);
      drive(1'b1, 64'h304, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("err_sticky", {63'h0, err}, 64'h1);
      drive(1'b0, 64'h304, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b0, 64'h304, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("err_cleared", {63'h0, err}, 64'h0);
      chk("err_rst_req", {63'h0, imem_req}, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
